mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Parametrised N-channel arbiter that merges several cache-miss ports onto one slow-memory line port.
//  Sits between L2 (or L1) cache mem-side ports and a single memory, so I- and D-hierarchies share one memory.
//  Round-robin fair, one outstanding transaction, read data held in a line buffer.
// PARAMETERS
//  NCH     2    number of requesting channels (1..8)
//  ADDR_W  28   line address width (byte addr [31:4])
//  LINE_W  128  line width in bits
// PORTS
//  clk         in   1             clock, all state on rising edge
//  proc_reset  in   1             synchronous active-high reset
//  ch_read     in   NCH           per-channel read request, held until ch_ready
//  ch_write    in   NCH           per-channel write request, held until ch_ready
//  ch_addr     in   NCH*ADDR_W    flattened line addresses, channel i at [i*ADDR_W +: ADDR_W]
//  ch_wdata    in   NCH*LINE_W    flattened write lines
//  ch_rdata    out  LINE_W        read line, shared by all channels, valid when any ch_ready bit is set
//  ch_ready    out  NCH           one-cycle completion pulse, one-hot
//  mem_read    out  1             memory read strobe
//  mem_write   out  1             memory write strobe
//  mem_addr    out  ADDR_W        memory line address
//  mem_wdata   out  LINE_W        memory write line
//  mem_rdata   in   LINE_W        memory read line, valid with mem_ready
//  mem_ready   in   1             memory completion pulse
// BEHAVIOUR
//  Reset, synchronous, wins over everything:
//   - state=IDLE; rr_ptr=0.
//   - all outputs 0: ch_ready, ch_rdata, mem_read, mem_write, mem_addr, mem_wdata.
//  FSM states: IDLE, ISSUE, RESP.
//  IDLE:
//   - req[i] = ch_read[i] | ch_write[i].
//   - Search channels rr_ptr, rr_ptr+1, ... modulo NCH; first requester wins (g).
//   - Register g, op, ch_addr[g], ch_wdata[g]; go to ISSUE.
//   - rr_ptr <= (g+1) mod NCH; wraps from NCH-1 to 0.
//   - No request: stay in IDLE, all strobes 0.
//  ISSUE:
//   - mem_read or mem_write held at 1 with the registered addr/wdata.
//   - Inputs are not re-sampled, so channel changes mid-transaction are ignored.
//   - On mem_ready: capture mem_rdata into line buffer (writes capture too, data unused); go to RESP.
//   - mem_read/mem_write drop to 0 in the cycle after mem_ready.
//  RESP (exactly one cycle):
//   - ch_ready[g]=1; ch_rdata=buffer; go to IDLE.
//   - Requester deasserts on this edge, so IDLE never re-grants a served request.
//  Latency: request seen in IDLE at cycle T -> mem strobe from T+1 -> mem_ready at cycle M -> ch_ready at M+1.
//  A channel asserting both read and write is illegal; write is performed, read ignored.
//  Simultaneous requests: losers wait, no starvation; worst-case wait is NCH-1 transactions.
//  mem_ready outside ISSUE is ignored.
//  ch_rdata holds its last value between responses.
//  NCH=1: rr_ptr is constant 0; behaves as a registered pass-through with one cycle in and one cycle out.
//  Reset mid-ISSUE: transaction abandoned; strobes 0 on the next cycle; memory must also be reset.
// CONFIGURATION
//  ARB_WRITE_PRIO_EN defined:
//   - In IDLE, any pending ch_write beats every read.
//   - Writes are chosen round-robin among writers from rr_ptr; rr_ptr updates as usual.
//   - Dirty writebacks therefore drain before refills.
//  ARB_WRITE_PRIO_EN undefined: pure round-robin over reads and writes.
// TESTING
//  1 Single read: NCH=2, ch0 read addr 28'h0000010, mem_ready after 5 cycles with rdata 128'hA5..A5
//    -> mem_read high 5 cycles; ch_ready=2'b01 one cycle later; ch_rdata=A5..A5.
//  2 Contention: ch0 and ch1 read in the same cycle, rr_ptr=0
//    -> ch0 served first, then ch1; ch_ready pulses 01 then 10; mem_addr switches correctly.
//  3 Fairness: ch0 re-requests immediately after every ready while ch1 holds a request
//    -> grants alternate 0,1,0,1; no grant twice in a row while the other channel is pending.
//  4 Write path: ch1 write addr 28'h1234567, wdata 128'hDEAD_BEEF..
//    -> mem_write=1, mem_addr=1234567, mem_wdata matches; mem_read stays 0; ch_ready=2'b10.
//  5 Reset mid-ISSUE: proc_reset=1 during the 3rd strobe cycle
//    -> next cycle all outputs 0 and state IDLE; first grant after reset goes to ch0.
//  6 With ARB_WRITE_PRIO_EN, NCH=4, rr_ptr=0: ch0 read and ch2 write together
//    -> ch2 granted first; without the macro ch0 is granted first.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of channel-side and memory-side signals for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the environment (caches + memory).
interface mem_port_arbiter_if #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
);
  logic [NCH-1:0]        ch_read;
  logic [NCH-1:0]        ch_write;
  logic [NCH*ADDR_W-1:0] ch_addr;
  logic [NCH*LINE_W-1:0] ch_wdata;
  logic [LINE_W-1:0]     ch_rdata;
  logic [NCH-1:0]        ch_ready;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_W-1:0]     mem_addr;
  logic [LINE_W-1:0]     mem_wdata;
  logic [LINE_W-1:0]     mem_rdata;
  logic                  mem_ready;

  modport slave (
    input  ch_read, ch_write, ch_addr, ch_wdata, mem_rdata, mem_ready,
    output ch_rdata, ch_ready, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output ch_read, ch_write, ch_addr, ch_wdata, mem_rdata, mem_ready,
    input  ch_rdata, ch_ready, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin N-channel arbiter merging cache-miss ports onto one memory line port.
// Define ARB_WRITE_PRIO_EN to let pending writes win over every read in IDLE.
module mem_port_arbiter #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  mem_port_arbiter_if.slave bus
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] buf_q, buf_d;
  logic [NCH-1:0]    ready_q, ready_d;
  logic              rd_stb_q, rd_stb_d;
  logic              wr_stb_q, wr_stb_d;

  logic [NCH-1:0]    req;
  logic [NCH-1:0]    cand;
  logic              found;
  int                pick;
  int                idx;
  logic              pick_wr;

  // Round-robin search starting at rr_ptr; the lowest offset with a candidate wins.
  always_comb begin
    req   = bus.ch_read | bus.ch_write;
`ifdef ARB_WRITE_PRIO_EN
    cand  = (|bus.ch_write) ? bus.ch_write : req;
`else
    cand  = req;
`endif
    found = 1'b0;
    pick  = 0;
    idx   = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NCH;
      if (cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    pick_wr = bus.ch_write[pick];
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    ready_d  = '0;
    rd_stb_d = rd_stb_q;
    wr_stb_d = wr_stb_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = ISSUE;
          gnt_d    = PW'(pick);
          rr_ptr_d = (pick == NCH - 1) ? '0 : PW'(pick + 1);
          addr_d   = bus.ch_addr[pick*ADDR_W +: ADDR_W];
          wdata_d  = bus.ch_wdata[pick*LINE_W +: LINE_W];
          // A channel raising both read and write gets the write.
          rd_stb_d = ~pick_wr;
          wr_stb_d = pick_wr;
        end
      end
      ISSUE: begin
        if (bus.mem_ready) begin
          state_d        = RESP;
          buf_d          = bus.mem_rdata;
          rd_stb_d       = 1'b0;
          wr_stb_d       = 1'b0;
          ready_d[gnt_q] = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      ready_q  <= '0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      ready_q  <= ready_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
    end
  end

  assign bus.ch_rdata  = buf_q;
  assign bus.ch_ready  = ready_q;
  assign bus.mem_read  = rd_stb_q;
  assign bus.mem_write = wr_stb_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a 2-channel instance with memory and requester
// models, plus a 4-channel instance for the write-priority ordering case.
module tb_mem_port_arbiter;
  localparam int AW = 28;
  localparam int LW = 128;
`ifdef ARB_WRITE_PRIO_EN
  localparam int FIRST4 = 2;
`else
  localparam int FIRST4 = 0;
`endif

  logic clk = 1'b0;
  logic proc_reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NCH(2), .ADDR_W(AW), .LINE_W(LW)) bus ();
  mem_port_arbiter_if #(.NCH(4), .ADDR_W(AW), .LINE_W(LW)) bus4 ();

  mem_port_arbiter #(.NCH(2), .ADDR_W(AW), .LINE_W(LW)) u_dut (
    .clk(clk), .proc_reset(proc_reset), .bus(bus));
  mem_port_arbiter #(.NCH(4), .ADDR_W(AW), .LINE_W(LW)) u_dut4 (
    .clk(clk), .proc_reset(proc_reset), .bus(bus4));

  typedef struct {
    int          ch;
    logic        wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } txn_t;

  txn_t issue_q[$];
  txn_t resp_q[$];
  txn_t chq0[$];
  txn_t chq1[$];
  logic [LW-1:0] mem_arr [logic [AW-1:0]];

  int n_vec = 0;
  int n_err = 0;
  int mem_lat = 3;
  int cnt = 0;
  int last_stb_len = 0;
  int cyc = 0;
  int ready_cyc = -10;
  bit stray = 1'b0;
  bit run = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LW-1:0] mem_lookup(logic [AW-1:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return {4{4'h5, a}};
  endfunction

  task automatic enqueue(int ch, logic wr, logic [AW-1:0] a, logic [LW-1:0] wd);
    txn_t t;
    t.ch = ch; t.wr = wr; t.addr = a; t.wdata = wd;
    t.rdata = wr ? ~wd : mem_lookup(a);
    issue_q.push_back(t);
    resp_q.push_back(t);
    if (ch == 0) chq0.push_back(t);
    else chq1.push_back(t);
  endtask

  // Requesters: present the head of each channel queue, retire it on ch_ready.
  initial begin
    bus.ch_read = '0; bus.ch_write = '0; bus.ch_addr = '0; bus.ch_wdata = '0;
    forever begin
      @(negedge clk);
      if (bus.ch_ready[0] === 1'b1 && chq0.size() > 0) void'(chq0.pop_front());
      if (bus.ch_ready[1] === 1'b1 && chq1.size() > 0) void'(chq1.pop_front());
      bus.ch_read[0]       = (chq0.size() > 0) && !chq0[0].wr;
      bus.ch_write[0]      = (chq0.size() > 0) && chq0[0].wr;
      bus.ch_addr[0 +: AW] = (chq0.size() > 0) ? chq0[0].addr : '0;
      bus.ch_wdata[0 +: LW] = (chq0.size() > 0) ? chq0[0].wdata : '0;
      bus.ch_read[1]       = (chq1.size() > 0) && !chq1[0].wr;
      bus.ch_write[1]      = (chq1.size() > 0) && chq1[0].wr;
      bus.ch_addr[AW +: AW] = (chq1.size() > 0) ? chq1[0].addr : '0;
      bus.ch_wdata[LW +: LW] = (chq1.size() > 0) ? chq1[0].wdata : '0;
    end
  end

  // Memory: answers mem_lat cycles into each strobe, checks the issued request.
  initial begin
    txn_t mt;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) begin
        if (cnt == 0) begin
          n_vec++;
          if (issue_q.size() == 0) begin
            n_err++;
            $display("FAIL issue: unexpected strobe rd=%b wr=%b addr=%h, required none",
                     bus.mem_read, bus.mem_write, bus.mem_addr);
          end else begin
            mt = issue_q.pop_front();
            if (bus.mem_read !== !mt.wr || bus.mem_write !== mt.wr || bus.mem_addr !== mt.addr ||
                (mt.wr && bus.mem_wdata !== mt.wdata)) begin
              n_err++;
              $display("FAIL issue: rd=%b wr=%b addr=%h wdata=%h, required rd=%b wr=%b addr=%h wdata=%h",
                       bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata,
                       !mt.wr, mt.wr, mt.addr, mt.wdata);
            end
          end
        end
        cnt++;
        if (cnt == mem_lat) begin
          bus.mem_ready = 1'b1;
          ready_cyc = cyc;
          if (bus.mem_write) begin
            bus.mem_rdata = ~bus.mem_wdata;
            mem_arr[bus.mem_addr] = bus.mem_wdata;
          end else begin
            bus.mem_rdata = mem_lookup(bus.mem_addr);
          end
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = {4{$urandom}};
        end
      end else begin
        if (cnt != 0) last_stb_len = cnt;
        cnt = 0;
        bus.mem_ready = stray;
        bus.mem_rdata = {4{$urandom}};
      end
    end
  end

  // Response side: every ch_ready pulse must match the next expected completion.
  initial begin
    txn_t rt;
    logic [1:0] exp_r;
    forever begin
      @(negedge clk);
      if (run && bus.ch_ready !== 2'b00) begin
        n_vec++;
        if (resp_q.size() == 0) begin
          n_err++;
          $display("FAIL resp: unexpected ch_ready=%b, required 00", bus.ch_ready);
        end else begin
          rt = resp_q.pop_front();
          exp_r = 2'(1 << rt.ch);
          if (bus.ch_ready !== exp_r || bus.ch_rdata !== rt.rdata || cyc != ready_cyc + 1) begin
            n_err++;
            $display("FAIL resp: ch_ready=%b rdata=%h lat=%0d, required ch_ready=%b rdata=%h lat=1",
                     bus.ch_ready, bus.ch_rdata, cyc - ready_cyc, exp_r, rt.rdata);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_done(string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (issue_q.size() == 0 && resp_q.size() == 0) break;
    end
    n_vec++;
    if (issue_q.size() != 0 || resp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s timeout: %0d issues, %0d responses outstanding, required 0",
               name, issue_q.size(), resp_q.size());
      issue_q.delete(); resp_q.delete(); chq0.delete(); chq1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    n_vec++;
    if ({bus.ch_ready, bus.mem_read, bus.mem_write} !== 4'b0 || bus.mem_addr !== '0 ||
        bus.mem_wdata !== '0 || bus.ch_rdata !== '0) begin
      n_err++;
      $display("FAIL reset2: rdy=%b rd=%b wr=%b addr=%h, required all 0",
               bus.ch_ready, bus.mem_read, bus.mem_write, bus.mem_addr);
    end
    n_vec++;
    if (bus4.ch_ready !== 4'b0 || bus4.mem_read !== 1'b0 || bus4.mem_write !== 1'b0) begin
      n_err++;
      $display("FAIL reset4: rdy=%b rd=%b wr=%b, required 0", bus4.ch_ready, bus4.mem_read, bus4.mem_write);
    end
  endtask

  task automatic test_single_read();
    mem_lat = 5;
    mem_arr[28'h0000010] = {16{8'hA5}};
    enqueue(0, 1'b0, 28'h0000010, '0);
    wait_done("single_read");
    n_vec++;
    if (last_stb_len != 5) begin
      n_err++;
      $display("FAIL read_strobe_len: got %0d cycles, required 5", last_stb_len);
    end
    stray = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.ch_rdata !== {16{8'hA5}} || bus.ch_ready !== 2'b00 || bus.mem_read !== 1'b0) begin
      n_err++;
      $display("FAIL stray_ready: rdata=%h rdy=%b rd=%b, required rdata=a5.. rdy=00 rd=0",
               bus.ch_rdata, bus.ch_ready, bus.mem_read);
    end
  endtask

  task automatic test_write_path();
    mem_lat = 2;
    enqueue(1, 1'b1, 28'h1234567, {4{32'hDEAD_BEEF}});
    wait_done("write_path");
  endtask

  task automatic test_contention();
    mem_lat = 3;
    enqueue(0, 1'b0, 28'h0000300, '0);
    enqueue(1, 1'b0, 28'h0000400, '0);
    wait_done("contention");
  endtask

  task automatic test_fairness();
    mem_lat = 1;
    enqueue(0, 1'b0, 28'h0000100, '0);
    enqueue(1, 1'b0, 28'h0000200, '0);
    enqueue(0, 1'b0, 28'h0000101, '0);
    enqueue(1, 1'b1, 28'h0000201, {4{32'h0BAD_F00D}});
    enqueue(0, 1'b0, 28'h0000102, '0);
    wait_done("fairness");
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    mem_lat = 10;
    enqueue(0, 1'b0, 28'h0000AB0, '0);
    for (int i = 0; i < 50 && seen < 3; i++) begin
      @(negedge clk);
      if (bus.mem_read === 1'b1) seen++;
    end
    proc_reset = 1'b1;
    issue_q.delete(); resp_q.delete(); chq0.delete(); chq1.delete();
    @(negedge clk);
    proc_reset = 1'b0;
    n_vec++;
    if (seen != 3 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_addr !== '0 ||
        bus.mem_wdata !== '0 || bus.ch_ready !== 2'b00 || bus.ch_rdata !== '0) begin
      n_err++;
      $display("FAIL reset_mid: seen=%0d rd=%b wr=%b addr=%h rdy=%b rdata=%h, required seen=3 and all 0",
               seen, bus.mem_read, bus.mem_write, bus.mem_addr, bus.ch_ready, bus.ch_rdata);
    end
    mem_lat = 2;
    enqueue(0, 1'b0, 28'h0000500, '0);
    enqueue(1, 1'b0, 28'h0000600, '0);
    wait_done("after_reset");
  endtask

  task automatic test_write_prio();
    logic [AW-1:0] a0 = 28'h0000C00;
    logic [AW-1:0] a2 = 28'h0000C20;
    logic [LW-1:0] w2 = {4{32'h2222_0000}};
    int order[2];
    order[0] = FIRST4;
    order[1] = (FIRST4 == 2) ? 0 : 2;
    @(negedge clk);
    bus4.ch_read = 4'b0001;
    bus4.ch_write = 4'b0100;
    bus4.ch_addr[0 +: AW] = a0;
    bus4.ch_addr[2*AW +: AW] = a2;
    bus4.ch_wdata[2*LW +: LW] = w2;
    for (int k = 0; k < 2; k++) begin
      logic [AW-1:0] ea;
      logic [LW-1:0] rd;
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus4.mem_read === 1'b1 || bus4.mem_write === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      ea = (order[k] == 2) ? a2 : a0;
      rd = {4{$urandom}};
      n_vec++;
      if (!ok || bus4.mem_addr !== ea || bus4.mem_write !== (order[k] == 2)) begin
        n_err++;
        $display("FAIL prio_grant%0d: strobe=%b addr=%h wr=%b, required addr=%h wr=%b",
                 k, ok, bus4.mem_addr, bus4.mem_write, ea, (order[k] == 2));
      end
      bus4.mem_ready = 1'b1;
      bus4.mem_rdata = rd;
      @(negedge clk);
      bus4.mem_ready = 1'b0;
      n_vec++;
      if (bus4.ch_ready !== 4'(1 << order[k]) || bus4.ch_rdata !== rd) begin
        n_err++;
        $display("FAIL prio_ready%0d: rdy=%b rdata=%h, required rdy=%b rdata=%h",
                 k, bus4.ch_ready, bus4.ch_rdata, 4'(1 << order[k]), rd);
      end
      if (order[k] == 2) bus4.ch_write = '0;
      else bus4.ch_read = '0;
    end
  endtask

  initial begin
    proc_reset = 1'b1;
    bus4.ch_read = '0; bus4.ch_write = '0; bus4.ch_addr = '0; bus4.ch_wdata = '0;
    bus4.mem_ready = 1'b0; bus4.mem_rdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    proc_reset = 1'b0;
    run = 1'b1;
    @(negedge clk);
    test_single_read();
    test_write_path();
    test_contention();
    test_fairness();
    test_reset_mid();
    test_write_prio();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
